// File: rtl/rv_instr_decode_pkg.sv
// Shared RV32I decode definitions: opcode constants, NOP encoding, field positions
// and the registered field bundle used by the decoder.
package rv_instr_decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned IMM20_LSB  = 12;
  localparam int unsigned IMM12_LSB  = 20;

  typedef struct packed {
    logic [6:0]  opCode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [19:0] imm20;
    logic [11:0] imm12;
    logic [11:0] imm12SClass;
    logic [31:0] imm12Ext;
    logic [31:0] imm12SClassExt;
  } decodeFields_t;

endpackage

// File: rtl/rv_sign_extend_12_32.sv
// Combinational 12-bit to 32-bit two's-complement sign extension.
module rv_sign_extend_12_32 (
  input  logic [11:0] iwValue,
  output logic [31:0] owExtended
);

  assign owExtended = {{20{iwValue[11]}}, iwValue};

endmodule

// File: rtl/rv_instr_decode.sv
// RV32I field decoder: slices one instruction word into raw fields and
// sign-extended immediates, captured together in a single register bank.
module rv_instr_decode
  import rv_instr_decode_pkg::*;
(
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic        iwEnable,
  input  logic [31:0] iwInstr,
  output logic [6:0]  orOpCode,
  output logic [4:0]  orRd,
  output logic [2:0]  orFunct3,
  output logic [4:0]  orRs1,
  output logic [4:0]  orRs2,
  output logic [6:0]  orFunct7,
  output logic [19:0] orImmediate20,
  output logic [11:0] orImmediate12,
  output logic [11:0] orImmediate12SClass,
  output logic [31:0] orImmediate12Extended,
  output logic [31:0] orImmediate12SClassExtended
);

  decodeFields_t wNext;
  decodeFields_t rDec;
  logic [11:0]   wImm12;
  logic [11:0]   wImm12SClass;
  logic [31:0]   wImm12Ext;
  logic [31:0]   wImm12SClassExt;

  assign wImm12      = iwInstr[IMM12_LSB +: 12];
  assign wImm12SClass = {iwInstr[FUNCT7_LSB +: 7], iwInstr[RD_LSB +: 5]};

  // Extension happens before the register so raw and extended fields move together.
  rv_sign_extend_12_32 uImm12Ext (
    .iwValue    (wImm12),
    .owExtended (wImm12Ext)
  );

  rv_sign_extend_12_32 uImm12SClassExt (
    .iwValue    (wImm12SClass),
    .owExtended (wImm12SClassExt)
  );

  always_comb begin
    wNext                = '0;
    wNext.opCode         = iwInstr[OPCODE_LSB +: 7];
    wNext.rd             = iwInstr[RD_LSB +: 5];
    wNext.funct3         = iwInstr[FUNCT3_LSB +: 3];
    wNext.rs1            = iwInstr[RS1_LSB +: 5];
    wNext.rs2            = iwInstr[RS2_LSB +: 5];
    wNext.funct7         = iwInstr[FUNCT7_LSB +: 7];
    wNext.imm20          = iwInstr[IMM20_LSB +: 20];
    wNext.imm12          = wImm12;
    wNext.imm12SClass    = wImm12SClass;
    wNext.imm12Ext       = wImm12Ext;
    wNext.imm12SClassExt = wImm12SClassExt;
  end

  // Reset loads the NOP decode and wins over enable; enable low holds the whole bank.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      rDec        <= '0;
      rDec.opCode <= NOP_INSTR[6:0];
    end else if (iwEnable) begin
      rDec <= wNext;
    end
  end

  assign orOpCode                    = rDec.opCode;
  assign orRd                        = rDec.rd;
  assign orFunct3                    = rDec.funct3;
  assign orRs1                       = rDec.rs1;
  assign orRs2                       = rDec.rs2;
  assign orFunct7                    = rDec.funct7;
  assign orImmediate20               = rDec.imm20;
  assign orImmediate12               = rDec.imm12;
  assign orImmediate12SClass         = rDec.imm12SClass;
  assign orImmediate12Extended       = rDec.imm12Ext;
  assign orImmediate12SClassExtended = rDec.imm12SClassExt;

endmodule

// File: tb/tb_rv_instr_decode.sv
// Bench for rv_instr_decode: directed RV32I words plus randomized words/stalls/resets
// checked against an arithmetic field model of the last captured word.
module tb_rv_instr_decode;

  logic        iwClk = 1'b0;
  logic        iwRst = 1'b1;
  logic        iwEnable = 1'b0;
  logic [31:0] iwInstr = 32'h0;
  logic [6:0]  orOpCode;
  logic [4:0]  orRd;
  logic [2:0]  orFunct3;
  logic [4:0]  orRs1;
  logic [4:0]  orRs2;
  logic [6:0]  orFunct7;
  logic [19:0] orImmediate20;
  logic [11:0] orImmediate12;
  logic [11:0] orImmediate12SClass;
  logic [31:0] orImmediate12Extended;
  logic [31:0] orImmediate12SClassExtended;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  logic [31:0] modelWord = 32'h0000_0013;

  rv_instr_decode dut (
    .iwClk                       (iwClk),
    .iwRst                       (iwRst),
    .iwEnable                    (iwEnable),
    .iwInstr                     (iwInstr),
    .orOpCode                    (orOpCode),
    .orRd                        (orRd),
    .orFunct3                    (orFunct3),
    .orRs1                       (orRs1),
    .orRs2                       (orRs2),
    .orFunct7                    (orFunct7),
    .orImmediate20               (orImmediate20),
    .orImmediate12               (orImmediate12),
    .orImmediate12SClass         (orImmediate12SClass),
    .orImmediate12Extended       (orImmediate12Extended),
    .orImmediate12SClassExtended (orImmediate12SClassExtended)
  );

  always #5 iwClk = ~iwClk;

  // Two's-complement value of a 12-bit field, returned as a 32-bit pattern.
  function automatic logic [31:0] signed12(input logic [31:0] raw);
    int v;
    v = int'(raw % 4096);
    if (v >= 2048) v = v - 4096;
    return 32'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string ctx);
    logic [31:0] w;
    logic [31:0] sRaw;
    w = modelWord;
    sRaw = ((w / 32'd33554432) * 32'd32) + ((w / 32'd128) % 32'd32);
    check({ctx, ".opCode"}, 32'(orOpCode), w % 128);
    check({ctx, ".rd"}, 32'(orRd), (w / 128) % 32);
    check({ctx, ".funct3"}, 32'(orFunct3), (w / 4096) % 8);
    check({ctx, ".rs1"}, 32'(orRs1), (w / 32768) % 32);
    check({ctx, ".rs2"}, 32'(orRs2), (w / 1048576) % 32);
    check({ctx, ".funct7"}, 32'(orFunct7), w / 33554432);
    check({ctx, ".imm20"}, 32'(orImmediate20), w / 4096);
    check({ctx, ".imm12"}, 32'(orImmediate12), w / 1048576);
    check({ctx, ".imm12S"}, 32'(orImmediate12SClass), sRaw);
    check({ctx, ".imm12Ext"}, orImmediate12Extended, signed12(w / 1048576));
    check({ctx, ".imm12SExt"}, orImmediate12SClassExtended, signed12(sRaw));
  endtask

  // Drive on the falling edge, let one rising edge pass, update the model, compare.
  task automatic step(input logic rst, input logic en, input logic [31:0] word, input string ctx);
    @(negedge iwClk);
    iwRst = rst;
    iwEnable = en;
    iwInstr = word;
    @(posedge iwClk);
    #1;
    if (rst) modelWord = 32'h0000_0013;
    else if (en) modelWord = word;
    checkAll(ctx);
  endtask

  initial begin
    logic r;
    logic e;
    logic [31:0] w;

    step(1'b1, 1'b0, 32'hDEAD_BEEF, "reset");
    check("reset.opCodeConst", 32'(orOpCode), 32'h13);
    check("reset.imm20Const", 32'(orImmediate20), 32'h0);
    step(1'b0, 1'b0, 32'hFFFF_FFFF, "resetHold");
    check("resetHold.rdConst", 32'(orRd), 32'h0);

    step(1'b0, 1'b1, 32'hFFF1_0093, "addi");
    check("addi.rs1Const", 32'(orRs1), 32'd2);
    check("addi.extConst", orImmediate12Extended, 32'hFFFF_FFFF);

    step(1'b0, 1'b1, 32'hFE55_2E23, "sw");
    check("sw.funct3Const", 32'(orFunct3), 32'd2);
    check("sw.sExtConst", orImmediate12SClassExtended, 32'hFFFF_FFFC);

    step(1'b0, 1'b1, 32'h1234_51B7, "lui");
    check("lui.imm20Const", 32'(orImmediate20), 32'h12345);

    step(1'b0, 1'b1, 32'h4062_8233, "sub");
    check("sub.funct7Const", 32'(orFunct7), 32'h20);
    check("sub.rs2Const", 32'(orRs2), 32'd6);

    step(1'b0, 1'b1, 32'h7FF0_0013, "imm7FF");
    check("imm7FF.extConst", orImmediate12Extended, 32'h0000_07FF);
    step(1'b0, 1'b1, 32'h8000_0013, "imm800");
    check("imm800.extConst", orImmediate12Extended, 32'hFFFF_F800);

    step(1'b0, 1'b0, 32'h1234_51B7, "stall");
    check("stall.imm12Const", 32'(orImmediate12), 32'h800);
    step(1'b1, 1'b1, 32'hFE55_2E23, "rstOverEn");
    check("rstOverEn.opCodeConst", 32'(orOpCode), 32'h13);
    check("rstOverEn.sExtConst", orImmediate12SClassExtended, 32'h0);

    step(1'b0, 1'b1, 32'hFFF1_0093, "preStall");
    step(1'b0, 1'b0, 32'h4062_8233, "midStall");
    step(1'b1, 1'b0, 32'h4062_8233, "rstMidStall");
    check("rstMidStall.imm12Const", 32'(orImmediate12), 32'h0);

    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      w = $urandom();
      step(r, e, w, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
